// File: rtl/acq_search_ctrl.sv
// Doppler-bin search sequencer: requests each bin from the NCO, gates one FFT frame
// into the peak detector, tracks the global best peak and reports a threshold decision.
module acq_search_ctrl #(
    parameter int DSIZE           = 32,
    parameter int DSIZE_DIV2      = 16,
    parameter int FFT_LENGTH_LOG2 = 16,
    parameter int BINS_LOG2       = 6
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  i_start,
    input  logic [BINS_LOG2-1:0]  i_num_bins,
    input  logic [DSIZE_DIV2-1:0] i_threshold,
    output logic [BINS_LOG2-1:0]  o_dop_bin,
    output logic                  o_dop_req,
    input  logic                  i_dop_ack,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tlast,
    input  logic [DSIZE-1:0]      s00_axis_tdata,
    output logic                  s00_axis_tready,
    output logic                  pd_tvalid,
    output logic                  pd_tlast,
    output logic [DSIZE-1:0]      pd_tdata,
    output logic [DSIZE_DIV2-1:0] pd_index,
    input  logic [DSIZE_DIV2-1:0] pd_max,
    input  logic [DSIZE_DIV2-1:0] pd_max_index,
    input  logic                  pd_done,
    output logic                  o_busy,
    output logic                  o_result_valid,
    output logic                  o_hit,
    output logic [BINS_LOG2-1:0]  o_best_bin,
    output logic [DSIZE_DIV2-1:0] o_best_phase,
    output logic [DSIZE_DIV2-1:0] o_best_mag,
    output logic                  o_gap_err,
    output logic                  o_len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_WAIT,
        S_UPDATE,
        S_REPORT
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [BINS_LOG2-1:0]       bin;
    logic [BINS_LOG2-1:0]       last_bin;
    logic [DSIZE_DIV2-1:0]      threshold_q;
    logic [FFT_LENGTH_LOG2-1:0] index;
    logic                       beat;
    logic                       upd_replace;
    logic [DSIZE_DIV2-1:0]      upd_mag;

    assign s00_axis_tready = (state == S_STREAM);
    assign beat            = s00_axis_tvalid & s00_axis_tready;
    assign pd_tvalid       = beat;
    assign pd_tlast        = s00_axis_tlast & s00_axis_tready;
    assign pd_tdata        = s00_axis_tready ? s00_axis_tdata : '0;
    assign pd_index        = s00_axis_tready ? DSIZE_DIV2'(index) : '0;
    assign o_dop_bin       = bin;

    // Strict compare keeps the earlier bin on ties
    assign upd_replace = (pd_max > o_best_mag);
    assign upd_mag     = upd_replace ? pd_max : o_best_mag;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (i_start) state_next = S_REQ;
            S_REQ:    if (i_dop_ack) state_next = S_STREAM;
            S_STREAM: if (beat && s00_axis_tlast) state_next = S_WAIT;
            // Detector max lags done by one cycle, so UPDATE samples it on the following cycle
            S_WAIT:   if (pd_done) state_next = S_UPDATE;
            S_UPDATE: state_next = (bin == last_bin) ? S_REPORT : S_REQ;
            S_REPORT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            bin            <= '0;
            last_bin       <= '0;
            threshold_q    <= '0;
            index          <= '0;
            o_dop_req      <= 1'b0;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
            o_hit          <= 1'b0;
            o_best_bin     <= '0;
            o_best_phase   <= '0;
            o_best_mag     <= '0;
            o_gap_err      <= 1'b0;
            o_len_err      <= 1'b0;
        end else begin
            o_dop_req      <= (state_next == S_REQ);
            o_busy         <= (state_next != S_IDLE);
            o_result_valid <= (state_next == S_REPORT);
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        last_bin     <= (i_num_bins == '0) ? '0 : i_num_bins - 1'b1;
                        threshold_q  <= i_threshold;
                        bin          <= '0;
                        o_hit        <= 1'b0;
                        o_best_bin   <= '0;
                        o_best_phase <= '0;
                        o_best_mag   <= '0;
                        o_gap_err    <= 1'b0;
                        o_len_err    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (i_dop_ack) index <= '0;
                end
                S_STREAM: begin
                    if (beat) index <= index + 1'b1;
                    if (!s00_axis_tvalid && index != '0) o_gap_err <= 1'b1;
                    if (beat && s00_axis_tlast && index != '1) o_len_err <= 1'b1;
                end
                S_UPDATE: begin
                    if (upd_replace) begin
                        o_best_mag   <= pd_max;
                        o_best_phase <= pd_max_index;
                        o_best_bin   <= bin;
                    end
                    // Hit is computed from the post-update best so it aligns with result_valid
                    if (bin == last_bin) o_hit <= (upd_mag > threshold_q);
                    else                 bin   <= bin + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed self-checking bench for acq_search_ctrl with a behavioural peak-detector
// driver; frames are 16 beats (FFT_LENGTH_LOG2 = 4).
module tb_acq_search_ctrl;

    localparam int DSIZE      = 32;
    localparam int DSIZE_DIV2 = 16;
    localparam int FFTL2      = 4;
    localparam int BINS_LOG2  = 6;

    logic                  s00_axis_aclk = 1'b0;
    logic                  s00_axis_aresetn;
    logic                  i_start;
    logic [BINS_LOG2-1:0]  i_num_bins;
    logic [DSIZE_DIV2-1:0] i_threshold;
    logic [BINS_LOG2-1:0]  o_dop_bin;
    logic                  o_dop_req;
    logic                  i_dop_ack;
    logic                  s00_axis_tvalid;
    logic                  s00_axis_tlast;
    logic [DSIZE-1:0]      s00_axis_tdata;
    logic                  s00_axis_tready;
    logic                  pd_tvalid;
    logic                  pd_tlast;
    logic [DSIZE-1:0]      pd_tdata;
    logic [DSIZE_DIV2-1:0] pd_index;
    logic [DSIZE_DIV2-1:0] pd_max;
    logic [DSIZE_DIV2-1:0] pd_max_index;
    logic                  pd_done;
    logic                  o_busy;
    logic                  o_result_valid;
    logic                  o_hit;
    logic [BINS_LOG2-1:0]  o_best_bin;
    logic [DSIZE_DIV2-1:0] o_best_phase;
    logic [DSIZE_DIV2-1:0] o_best_mag;
    logic                  o_gap_err;
    logic                  o_len_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] mx [4];
    logic [15:0] ph [4];
    bit          aborted;

    acq_search_ctrl #(
        .DSIZE(DSIZE), .DSIZE_DIV2(DSIZE_DIV2), .FFT_LENGTH_LOG2(FFTL2), .BINS_LOG2(BINS_LOG2)
    ) dut (
        .s00_axis_aclk(s00_axis_aclk), .s00_axis_aresetn(s00_axis_aresetn),
        .i_start(i_start), .i_num_bins(i_num_bins), .i_threshold(i_threshold),
        .o_dop_bin(o_dop_bin), .o_dop_req(o_dop_req), .i_dop_ack(i_dop_ack),
        .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tready(s00_axis_tready),
        .pd_tvalid(pd_tvalid), .pd_tlast(pd_tlast), .pd_tdata(pd_tdata), .pd_index(pd_index),
        .pd_max(pd_max), .pd_max_index(pd_max_index), .pd_done(pd_done),
        .o_busy(o_busy), .o_result_valid(o_result_valid), .o_hit(o_hit),
        .o_best_bin(o_best_bin), .o_best_phase(o_best_phase), .o_best_mag(o_best_mag),
        .o_gap_err(o_gap_err), .o_len_err(o_len_err)
    );

    always #5 s00_axis_aclk = ~s00_axis_aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One Doppler bin: answer the request, stream a frame, then play the detector
    task automatic applyStimulus(input int bin, input int len, input int gapAt, input int abortAt,
                                 input int ackDelay, input logic [15:0] maxVal,
                                 input logic [15:0] maxIdx, output bit abortedOut);
        int cyc;
        logic [31:0] word;
        abortedOut = 1'b0;
        cyc = 0;
        while (!o_dop_req && cyc < 20) begin
            @(negedge s00_axis_aclk);
            cyc++;
        end
        checkOutput("dop_req", 32'(o_dop_req), 32'd1);
        checkOutput("dop_bin", 32'(o_dop_bin), 32'(bin));
        for (int d = 0; d < ackDelay; d++) begin
            s00_axis_tvalid = 1'b1;
            pd_done = (d == 1);
            #1;
            checkOutput("tready_pre_ack", 32'(s00_axis_tready), 32'd0);
            checkOutput("pd_tvalid_pre_ack", 32'(pd_tvalid), 32'd0);
            checkOutput("dop_bin_stable", 32'(o_dop_bin), 32'(bin));
            @(negedge s00_axis_aclk);
        end
        s00_axis_tvalid = 1'b0;
        pd_done = 1'b0;
        i_dop_ack = 1'b1;
        @(negedge s00_axis_aclk);
        i_dop_ack = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == gapAt) begin
                s00_axis_tvalid = 1'b0;
                #1;
                checkOutput("gap_tready", 32'(s00_axis_tready), 32'd1);
                checkOutput("gap_pd_tvalid", 32'(pd_tvalid), 32'd0);
                @(negedge s00_axis_aclk);
            end
            if (i == abortAt) begin
                abortedOut = 1'b1;
                return;
            end
            word = {16'(i + 16'h100), 16'(bin)};
            s00_axis_tvalid = 1'b1;
            s00_axis_tlast  = (i == len - 1);
            s00_axis_tdata  = word;
            #1;
            checkOutput("pd_index", 32'(pd_index), 32'(i));
            checkOutput("pd_tvalid", 32'(pd_tvalid), 32'd1);
            checkOutput("pd_tdata", pd_tdata, word);
            @(negedge s00_axis_aclk);
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        pd_max       = 16'hFFFF;
        pd_max_index = 16'hFFFF;
        #1;
        checkOutput("wait_tready", 32'(s00_axis_tready), 32'd0);
        @(negedge s00_axis_aclk);
        pd_done = 1'b1;
        @(negedge s00_axis_aclk);
        pd_done      = 1'b0;
        pd_max       = maxVal;
        pd_max_index = maxIdx;
    endtask

    task automatic runSweep(input int nb, input logic [15:0] thr, input int ackDelay,
                            input int gapBin, input int shortBin, input int expBin,
                            input int expPhase, input int expMag, input int expHit,
                            input int expGap, input int expLen);
        int eff;
        int pulses;
        bit ab;
        i_num_bins  = 6'(nb);
        i_threshold = thr;
        i_start = 1'b1;
        @(negedge s00_axis_aclk);
        i_start = 1'b0;
        checkOutput("busy_start", 32'(o_busy), 32'd1);
        eff = (nb == 0) ? 1 : nb;
        for (int b = 0; b < eff; b++) begin
            applyStimulus(b, (b == shortBin) ? 10 : 16, (b == gapBin) ? 6 : -1, -1,
                          ackDelay, mx[b], ph[b], ab);
        end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge s00_axis_aclk);
            if (o_result_valid) begin
                pulses++;
                checkOutput("best_bin", 32'(o_best_bin), 32'(expBin));
                checkOutput("best_phase", 32'(o_best_phase), 32'(expPhase));
                checkOutput("best_mag", 32'(o_best_mag), 32'(expMag));
                checkOutput("hit", 32'(o_hit), 32'(expHit));
                checkOutput("gap_err", 32'(o_gap_err), 32'(expGap));
                checkOutput("len_err", 32'(o_len_err), 32'(expLen));
            end
        end
        checkOutput("result_pulses", 32'(pulses), 32'd1);
        checkOutput("busy_end", 32'(o_busy), 32'd0);
        checkOutput("hold_mag", 32'(o_best_mag), 32'(expMag));
        checkOutput("hold_hit", 32'(o_hit), 32'(expHit));
    endtask

    initial begin
        s00_axis_aresetn = 1'b0;
        i_start = 1'b0;
        i_num_bins = '0;
        i_threshold = '0;
        i_dop_ack = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast = 1'b0;
        s00_axis_tdata = 32'hA5A5_5A5A;
        pd_max = '0;
        pd_max_index = '0;
        pd_done = 1'b0;
        #3;
        checkOutput("rst_tready", 32'(s00_axis_tready), 32'd0);
        checkOutput("rst_pd_tdata", pd_tdata, 32'd0);
        checkOutput("rst_req", 32'(o_dop_req), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_best_mag", 32'(o_best_mag), 32'd0);
        checkOutput("rst_errs", {30'd0, o_gap_err, o_len_err}, 32'd0);
        @(negedge s00_axis_aclk);
        @(negedge s00_axis_aclk);
        s00_axis_aresetn = 1'b1;
        @(negedge s00_axis_aclk);

        $display("[TB] sweep: maxes 10/50/30, threshold 40");
        mx[0] = 16'd10; mx[1] = 16'd50; mx[2] = 16'd30;
        ph[0] = 16'd3;  ph[1] = 16'd7;  ph[2] = 16'd1;
        runSweep(3, 16'd40, 0, -1, -1, 1, 7, 50, 1, 0, 0);

        $display("[TB] sweep: threshold equal to best");
        runSweep(3, 16'd50, 0, -1, -1, 1, 7, 50, 0, 0, 0);

        $display("[TB] sweep: tie between bins 0 and 2");
        mx[0] = 16'd20; mx[1] = 16'd5; mx[2] = 16'd20;
        ph[0] = 16'd4;  ph[1] = 16'd2; ph[2] = 16'd9;
        runSweep(3, 16'd40, 0, -1, -1, 0, 4, 20, 0, 0, 0);

        $display("[TB] sweep: gap in bin 0, short frame in bin 1");
        mx[0] = 16'd7; mx[1] = 16'd9;
        ph[0] = 16'd1; ph[1] = 16'd2;
        runSweep(2, 16'd5, 0, 0, 1, 1, 2, 9, 1, 1, 1);

        $display("[TB] sweep: acknowledge delayed 5 cycles");
        mx[0] = 16'd3; mx[1] = 16'd100;
        ph[0] = 16'd0; ph[1] = 16'd15;
        runSweep(2, 16'd99, 5, -1, -1, 1, 15, 100, 1, 0, 0);

        $display("[TB] reset during bin 1 stream");
        mx[0] = 16'd60; ph[0] = 16'd5;
        i_num_bins = 6'd3;
        i_threshold = 16'd10;
        i_start = 1'b1;
        @(negedge s00_axis_aclk);
        i_start = 1'b0;
        applyStimulus(0, 16, -1, -1, 0, mx[0], ph[0], aborted);
        applyStimulus(1, 16, -1, 5, 0, 16'd70, 16'd8, aborted);
        checkOutput("abort_reached", 32'(aborted), 32'd1);
        s00_axis_aresetn = 1'b0;
        #1;
        checkOutput("arst_tready", 32'(s00_axis_tready), 32'd0);
        checkOutput("arst_pd_tvalid", 32'(pd_tvalid), 32'd0);
        checkOutput("arst_busy", 32'(o_busy), 32'd0);
        checkOutput("arst_best_mag", 32'(o_best_mag), 32'd0);
        checkOutput("arst_best_phase", 32'(o_best_phase), 32'd0);
        s00_axis_tvalid = 1'b0;
        @(negedge s00_axis_aclk);
        s00_axis_aresetn = 1'b1;
        @(negedge s00_axis_aclk);
        mx[0] = 16'd25; ph[0] = 16'd11;
        runSweep(0, 16'd40, 0, -1, -1, 0, 11, 25, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
